// File: rtl/csr_timer_pkg.sv
// CSR numbers and TCFG/TICLR field positions shared by the timer bank and its channels.
package csr_timer_pkg;

    localparam logic [13:0] CsrTid       = 14'h040;
    localparam logic [13:0] CsrTcfgBase  = 14'h041;
    localparam logic [13:0] CsrTvalBase  = 14'h042;
    localparam logic [13:0] CsrTiclrBase = 14'h044;
    localparam int unsigned ChanStride   = 16;

    localparam int unsigned TcfgEnBit       = 0;
    localparam int unsigned TcfgPeriodicBit = 1;
    localparam int unsigned TcfgInitLsb     = 2;
    localparam int unsigned TiclrClrBit     = 0;

    function automatic logic [13:0] chan_csr(input logic [13:0] base, input int unsigned idx);
        return base + 14'(idx * ChanStride);
    endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: TCFG fields, countdown counter and registered interrupt pending.
module timer_chan
    import csr_timer_pkg::*;
#(
    parameter int unsigned TVAL_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_we_i,
    input  logic              clr_we_i,
    input  logic [TVAL_W-1:0] wmask_i,
    input  logic [TVAL_W-1:0] wdata_i,
    input  logic              stop_i,
    output logic [31:0]       cfg_rdata_o,
    output logic [31:0]       tval_rdata_o,
    output logic              int_o
);

    localparam int unsigned       InitW      = TVAL_W - 2;
    localparam logic [TVAL_W-1:0] CntAllOnes = '1;

    logic              en_q, en_d;
    logic              per_q, per_d;
    logic              pend_q, pend_d;
    logic [InitW-1:0]  init_q, init_d;
    logic [TVAL_W-1:0] cnt_q, cnt_d;
    logic              expire;
    logic              clr;

    always_comb begin
        en_d   = en_q;
        per_d  = per_q;
        init_d = init_q;
        if (cfg_we_i) begin
            en_d   = (wmask_i[TcfgEnBit] & wdata_i[TcfgEnBit])
                   | (~wmask_i[TcfgEnBit] & en_q);
            per_d  = (wmask_i[TcfgPeriodicBit] & wdata_i[TcfgPeriodicBit])
                   | (~wmask_i[TcfgPeriodicBit] & per_q);
            init_d = (wmask_i[TVAL_W-1:TcfgInitLsb] & wdata_i[TVAL_W-1:TcfgInitLsb])
                   | (~wmask_i[TVAL_W-1:TcfgInitLsb] & init_q);
        end
    end

    // A TCFG write that leaves EN clear freezes the count where it is.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_we_i) begin
            if (en_d) begin
                cnt_d = {init_d, 2'b00};
            end
        end else if (en_q && !stop_i && (cnt_q != CntAllOnes)) begin
            if (cnt_q == '0) begin
                cnt_d = per_q ? {init_q, 2'b00} : CntAllOnes;
            end else begin
                cnt_d = cnt_q - TVAL_W'(1);
            end
        end
    end

    assign expire = en_q && (cnt_q == '0);
    assign clr    = clr_we_i && wmask_i[TiclrClrBit] && wdata_i[TiclrClrBit];

    always_comb begin
        pend_d = pend_q;
        if (expire) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q   <= 1'b0;
            per_q  <= 1'b0;
            init_q <= '0;
            cnt_q  <= CntAllOnes;
            pend_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            per_q  <= per_d;
            init_q <= init_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign cfg_rdata_o  = 32'({init_q, per_q, en_q});
    assign tval_rdata_o = 32'(cnt_q);
    assign int_o        = pend_q;

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of CSR-programmed timer channels with a core-ID register and a 64-bit stable counter.
module csr_timer_bank
    import csr_timer_pkg::*;
#(
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned TVAL_W     = 32,
    parameter logic [31:0] CORE_ID    = 32'h0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [13:0]           csr_num,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wdata,
    input  logic                  timer_stop,
    output logic [31:0]           csr_rvalue,
    output logic                  csr_hit,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic [63:0]           cnt_value
);

    logic [31:0] tid_q, tid_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] cfg_rdata  [NUM_TIMERS];
    logic [31:0] tval_rdata [NUM_TIMERS];

    always_comb begin
        tid_d = tid_q;
        if (csr_we && (csr_num == CsrTid)) begin
            tid_d = (csr_wmask & csr_wdata) | (~csr_wmask & tid_q);
        end
        cnt_d = cnt_q + 64'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q <= CORE_ID;
            cnt_q <= '0;
        end else begin
            tid_q <= tid_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        logic cfg_we;
        logic clr_we;

        assign cfg_we = csr_we && (csr_num == chan_csr(CsrTcfgBase, g));
        assign clr_we = csr_we && (csr_num == chan_csr(CsrTiclrBase, g));

        timer_chan #(
            .TVAL_W(TVAL_W)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (resetn),
            .cfg_we_i    (cfg_we),
            .clr_we_i    (clr_we),
            .wmask_i     (csr_wmask[TVAL_W-1:0]),
            .wdata_i     (csr_wdata[TVAL_W-1:0]),
            .stop_i      (timer_stop),
            .cfg_rdata_o (cfg_rdata[g]),
            .tval_rdata_o(tval_rdata[g]),
            .int_o       (timer_int[g])
        );
    end

    always_comb begin
        csr_rvalue = '0;
        csr_hit    = 1'b0;
        if (csr_num == CsrTid) begin
            csr_hit    = 1'b1;
            csr_rvalue = tid_q;
        end
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (csr_num == chan_csr(CsrTcfgBase, i)) begin
                csr_hit    = 1'b1;
                csr_rvalue = cfg_rdata[i];
            end
            if (csr_num == chan_csr(CsrTvalBase, i)) begin
                csr_hit    = 1'b1;
                csr_rvalue = tval_rdata[i];
            end
            if (csr_num == chan_csr(CsrTiclrBase, i)) begin
                csr_hit = 1'b1;
            end
        end
    end

    assign cnt_value = cnt_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Self-checking bench for csr_timer_bank: CSR vector table, directed timer sequences, random vs model.
module tb_csr_timer_bank;

    localparam logic [31:0] CoreId = 32'h0000_00A5;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        timer_stop;
    logic [31:0] csr_rvalue;
    logic        csr_hit;
    logic [1:0]  timer_int;
    logic [63:0] cnt_value;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] edges = '0;

    // Reference state: TCFG kept as a whole 32-bit word per channel.
    logic [31:0] m_cfg  [2];
    logic [31:0] m_cnt  [2];
    logic        m_pend [2];
    logic [31:0] m_tid;
    logic [63:0] m_cv;

    typedef struct {
        logic [13:0] num;
        logic        we;
        logic [31:0] mask;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_rv;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    csr_timer_bank #(
        .NUM_TIMERS(2),
        .TVAL_W    (32),
        .CORE_ID   (CoreId)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .csr_num   (csr_num),
        .csr_we    (csr_we),
        .csr_wmask (csr_wmask),
        .csr_wdata (csr_wdata),
        .timer_stop(timer_stop),
        .csr_rvalue(csr_rvalue),
        .csr_hit   (csr_hit),
        .timer_int (timer_int),
        .cnt_value (cnt_value)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [13:0] num, input logic we, input logic [31:0] mk,
                          input logic [31:0] d, input logic st);
        csr_num    = num;
        csr_we     = we;
        csr_wmask  = mk;
        csr_wdata  = d;
        timer_stop = st;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        edges = edges + 64'd1;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] d);
        set_in(num, 1'b1, 32'hFFFF_FFFF, d, timer_stop);
        cycle();
        csr_we = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [13:0] num, input logic [31:0] exp);
        csr_we  = 1'b0;
        csr_num = num;
        #1;
        check(name, 64'(csr_rvalue), 64'(exp));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cfg[i]  = '0;
            m_cnt[i]  = 32'hFFFF_FFFF;
            m_pend[i] = 1'b0;
        end
        m_tid = CoreId;
        m_cv  = '0;
    endtask

    task automatic model_read(input logic [13:0] num, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (num == 14'h40) begin
            hit = 1'b1;
            val = m_tid;
        end
        for (int i = 0; i < 2; i++) begin
            if (num == 14'('h41 + 16 * i)) begin
                hit = 1'b1;
                val = m_cfg[i];
            end
            if (num == 14'('h42 + 16 * i)) begin
                hit = 1'b1;
                val = m_cnt[i];
            end
            if (num == 14'('h44 + 16 * i)) begin
                hit = 1'b1;
            end
        end
    endtask

    task automatic model_step(input logic [13:0] num, input logic we, input logic [31:0] mk,
                              input logic [31:0] d, input logic st);
        for (int i = 0; i < 2; i++) begin
            logic        tcfg;
            logic        tclr;
            logic        fire;
            logic [31:0] ncfg;
            tcfg = we && (num == 14'('h41 + 16 * i));
            tclr = we && (num == 14'('h44 + 16 * i)) && mk[0] && d[0];
            fire = m_cfg[i][0] && (m_cnt[i] == 0);
            ncfg = tcfg ? ((mk & d) | (~mk & m_cfg[i])) : m_cfg[i];
            if (tcfg) begin
                if (ncfg[0]) m_cnt[i] = ncfg & ~32'd3;
            end else if (m_cfg[i][0] && !st && (m_cnt[i] != 32'hFFFF_FFFF)) begin
                if (m_cnt[i] == 0 && m_cfg[i][1]) m_cnt[i] = m_cfg[i] & ~32'd3;
                else m_cnt[i] = m_cnt[i] - 32'd1;
            end
            if (fire) m_pend[i] = 1'b1;
            else if (tclr) m_pend[i] = 1'b0;
            m_cfg[i] = ncfg;
        end
        if (we && num == 14'h40) m_tid = (mk & d) | (~mk & m_tid);
        m_cv = m_cv + 64'd1;
    endtask

    task automatic do_reset();
        set_in(14'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b0;
        #1;
        check("rst_int", 64'(timer_int), 64'h0);
        check("rst_cnt", cnt_value, 64'h0);
        chk_rd("rst_tid", 14'h40, CoreId);
        chk_rd("rst_tval0", 14'h42, 32'hFFFF_FFFF);
        chk_rd("rst_tval1", 14'h52, 32'hFFFF_FFFF);
        chk_rd("rst_tcfg0", 14'h41, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        edges  = '0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{14'h40, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_00A5};
        vecs[1]  = '{14'h40, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 1'b1, 32'h0000_00A5};
        vecs[2]  = '{14'h40, 1'b0, 32'h0,         32'h0,         1'b1, 32'h1234_00A5};
        vecs[3]  = '{14'h41, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0};
        vecs[4]  = '{14'h41, 1'b1, 32'hFFFF_FFFE, 32'h0000_0017, 1'b1, 32'h0};
        vecs[5]  = '{14'h41, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0016};
        vecs[6]  = '{14'h42, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[7]  = '{14'h42, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[8]  = '{14'h42, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[9]  = '{14'h41, 1'b1, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_0016};
        vecs[10] = '{14'h41, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0014};
        vecs[11] = '{14'h43, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        vecs[12] = '{14'h44, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0};
        vecs[13] = '{14'h52, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[14] = '{14'h54, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0};
        vecs[15] = '{14'h61, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        vecs[16] = '{14'h3F, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        vecs[17] = '{14'h45, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};

        set_in(14'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        do_reset();

        for (int k = 0; k < 18; k++) begin
            set_in(vecs[k].num, vecs[k].we, vecs[k].mask, vecs[k].data, 1'b0);
            #1;
            check($sformatf("vec%0d_hit", k), 64'(csr_hit), 64'(vecs[k].exp_hit));
            check($sformatf("vec%0d_rv", k), 64'(csr_rvalue), 64'(vecs[k].exp_rv));
            cycle();
        end
        csr_we = 1'b0;
        check("vec_int", 64'(timer_int), 64'h0);
        check("vec_cnt", cnt_value, edges);

        // One-shot countdown with INITVAL=2.
        do_reset();
        wr(14'h41, 32'h9);
        chk_rd("os_t1", 14'h42, 32'd8);
        chk_rd("os_cfg", 14'h41, 32'h9);
        repeat (8) cycle();
        chk_rd("os_t9", 14'h42, 32'd0);
        check("os_int_t9", 64'(timer_int[0]), 64'h0);
        cycle();
        check("os_int_t10", 64'(timer_int[0]), 64'h1);
        chk_rd("os_t10", 14'h42, 32'hFFFF_FFFF);
        repeat (4) cycle();
        chk_rd("os_hold", 14'h42, 32'hFFFF_FFFF);
        check("os_int_hold", 64'(timer_int[0]), 64'h1);
        check("os_cnt", cnt_value, edges);

        // Periodic reload, clear, set/clear collision, freeze and EN=0 write.
        do_reset();
        wr(14'h41, 32'hB);
        chk_rd("per_t1", 14'h42, 32'd8);
        repeat (8) cycle();
        chk_rd("per_t9", 14'h42, 32'd0);
        check("per_int_t9", 64'(timer_int[0]), 64'h0);
        cycle();
        chk_rd("per_t10", 14'h42, 32'd8);
        check("per_int_t10", 64'(timer_int[0]), 64'h1);
        wr(14'h44, 32'h1);
        check("per_clr", 64'(timer_int[0]), 64'h0);
        chk_rd("per_t11", 14'h42, 32'd7);
        repeat (7) cycle();
        chk_rd("per_t18", 14'h42, 32'd0);
        check("per_int_t18", 64'(timer_int[0]), 64'h0);
        cycle();
        check("per_int_t19", 64'(timer_int[0]), 64'h1);
        chk_rd("per_t19", 14'h42, 32'd8);
        wr(14'h44, 32'h1);
        check("col_pre_clr", 64'(timer_int[0]), 64'h0);
        repeat (7) cycle();
        chk_rd("col_zero", 14'h42, 32'd0);
        wr(14'h44, 32'h1);
        check("col_set_wins", 64'(timer_int[0]), 64'h1);
        repeat (2) cycle();
        chk_rd("frz_pre", 14'h42, 32'd6);
        timer_stop = 1'b1;
        repeat (5) cycle();
        chk_rd("frz_hold", 14'h42, 32'd6);
        check("frz_cnt", cnt_value, edges);
        timer_stop = 1'b0;
        cycle();
        chk_rd("frz_resume", 14'h42, 32'd5);
        wr(14'h41, 32'h8);
        chk_rd("dis_hold", 14'h42, 32'd5);
        repeat (3) cycle();
        chk_rd("dis_hold3", 14'h42, 32'd5);
        chk_rd("dis_cfg", 14'h41, 32'h8);

        // Channel isolation and unmapped CSR.
        do_reset();
        wr(14'h51, 32'hB);
        chk_rd("iso_t1_ch1", 14'h52, 32'd8);
        chk_rd("iso_t1_ch0", 14'h42, 32'hFFFF_FFFF);
        repeat (9) cycle();
        check("iso_int", 64'(timer_int), 64'h2);
        chk_rd("iso_ch0_tval", 14'h42, 32'hFFFF_FFFF);
        chk_rd("iso_ch0_cfg", 14'h41, 32'h0);
        chk_rd("map_43_rv", 14'h43, 32'h0);
        check("map_43_hit", 64'(csr_hit), 64'h0);

        // Asynchronous reset in the middle of a countdown.
        wr(14'h40, 32'hDEAD_BEEF);
        wr(14'h41, 32'h101);
        repeat (3) cycle();
        chk_rd("mid_tval", 14'h42, 32'h0000_00FD);
        chk_rd("mid_tid", 14'h40, 32'hDEAD_BEEF);
        check("mid_int1", 64'(timer_int[1]), 64'h1);
        do_reset();

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [13:0] num;
            logic        we;
            logic [31:0] mk;
            logic [31:0] d;
            logic        st;
            logic        eh;
            logic [31:0] ev;
            case ($urandom_range(0, 9))
                0:       num = 14'h40;
                1, 7:    num = 14'h41;
                2:       num = 14'h42;
                3:       num = 14'h44;
                4:       num = 14'h51;
                5:       num = 14'h52;
                6:       num = 14'h54;
                8:       num = 14'($urandom);
                default: num = 14'h43;
            endcase
            we = ($urandom_range(0, 3) == 0);
            mk = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            d  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            st = ($urandom_range(0, 7) == 0);
            set_in(num, we, mk, d, st);
            #1;
            model_read(num, eh, ev);
            check("rnd_hit", 64'(csr_hit), 64'(eh));
            check("rnd_rv", 64'(csr_rvalue), 64'(ev));
            cycle();
            model_step(num, we, mk, d, st);
            check("rnd_int", 64'(timer_int), 64'({m_pend[1], m_pend[0]}));
            check("rnd_cnt", cnt_value, m_cv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_timer_bank.md
CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 Parameter NUM_TIMERS, default 2, meaning number of independent timer channels (1..8).
REQ-002 Parameter TVAL_W, default 32, meaning timer counter width (8..32); INITVAL field width is TVAL_W-2.
REQ-003 Parameter CORE_ID, default 32'h0, meaning reset value of TID.
REQ-004 clk  in  1  single clock for all state.
REQ-005 resetn  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-006 csr_num  in  14  CSR number for read and write.
REQ-007 csr_we  in  1  CSR write enable.
REQ-008 csr_wmask  in  32  per-bit write mask.
REQ-009 csr_wdata  in  32  write data.
REQ-010 timer_stop  in  1  debug freeze; halts all channel countdowns while high.
REQ-011 csr_rvalue  out  32  combinational read data for csr_num.
REQ-012 csr_hit  out  1  csr_num matches a CSR implemented here.
REQ-013 timer_int  out  NUM_TIMERS  per-channel registered timer-interrupt pending.
REQ-014 cnt_value  out  64  free-running stable counter.

Function
REQ-015 Map: TID=0x40; channel i: TCFG=0x41+16*i, TVAL=0x42+16*i, TICLR=0x44+16*i; any other csr_num gives csr_hit=0 and csr_rvalue=0.
REQ-016 Masked write: new field = wmask&wdata | ~wmask&old, for TID, TCFG.EN[0], TCFG.PERIODIC[1] and TCFG.INITVAL[TVAL_W-1:2]; TVAL is read-only.
REQ-017 TCFG read = {zero-ext, INITVAL, PERIODIC, EN}; TVAL read = zero-extended count; TICLR read = 0.
REQ-018 Count priority per channel: (1) TCFG write whose masked next EN=1 loads count = {next INITVAL, 2'b00}; (2) else if EN && !timer_stop && count!=all-ones, then count==0 reloads {INITVAL,2'b00} when PERIODIC, else decrements to all-ones; (3) else hold.
REQ-019 One-shot halt: count at all-ones with PERIODIC=0 stays all-ones until the next TCFG write with EN=1.
REQ-020 TCFG write with next EN=0 clears EN and leaves count unchanged.
REQ-021 Pending set: when EN=1 and count==0 in cycle T, timer_int[i]=1 from T+1; timer_stop does not block set.
REQ-022 Pending clear: csr_we to TICLR(i) with wmask[0]&wdata[0]=1 clears timer_int[i] next cycle; a simultaneous set wins over clear.
REQ-023 Channels are fully independent; a write to channel i never alters channel j.
REQ-024 cnt_value increments by 1 every cycle, wraps 2^64-1 -> 0, and ignores timer_stop.
REQ-025 TVAL_W<32: INITVAL write bits above TVAL_W-1 are ignored and read as 0.

Reset
REQ-026 While resetn=0, async: EN=0, PERIODIC=0, INITVAL=0, count=all-ones, timer_int=0, cnt_value=0, TID=CORE_ID.
REQ-027 Reset assertion mid-countdown aborts immediately; no pending survives reset.
REQ-028 First count/CSR write update occurs on the first clk edge after resetn deasserts.

Structure
REQ-029 Package csr_timer_pkg holds CSR numbers (TID, TCFG/TVAL/TICLR base, channel stride 16) and TCFG/TICLR field bit positions.
REQ-030 One sub-module timer_chan (EN, PERIODIC, INITVAL, count, pending) instantiated NUM_TIMERS times via generate; TID, cnt_value and read mux stay in csr_timer_bank.

Verification
REQ-031 One-shot: write TCFG0=0x9 (INITVAL=2, EN=1) at T -> TVAL0=8 at T+1, 0 at T+9, timer_int[0]=1 at T+10, TVAL0=0xFFFFFFFF held thereafter.
REQ-032 Periodic: TCFG0=0xB at T -> TVAL0 0 at T+9, 8 at T+10; timer_int[0] set at T+10; TICLR0 write 1 clears; set again at T+19.
REQ-033 Set/clear collision: TICLR0 write on the cycle count==0 -> timer_int[0] remains 1.
REQ-034 Freeze: timer_stop=1 for 5 cycles mid-count -> TVAL0 holds value; cnt_value still advances by 5.
REQ-035 Isolation and map: NUM_TIMERS=2, program TCFG1 (0x51) only -> channel 0 stays 0xFFFFFFFF; read 0x43 -> csr_hit=0, csr_rvalue=0.
REQ-036 Reset mid-run: resetn low during countdown -> TVAL=0xFFFFFFFF, timer_int=0, cnt_value=0 asynchronously, TID=CORE_ID.
